// File: rtl/mod_instruction_mem.sv
// Instruction memory with a request/response fetch port and a program-load port.
// A fetch takes 1 + WAIT_CYCLES cycles from the accepting edge until rsp_valid rises.
module mod_instruction_mem #(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy
);

    localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              err_q, err_d;
    logic              capture;
    logic              accept;
    logic              cap_ok;
    logic              ld_ok;

    logic [DATA_W-1:0] mem [DEPTH];

    assign req_ready = (state_q == S_IDLE) && !ld_en && !rst;
    assign accept    = req_valid && req_ready;
    // Full-width compares so high address bits never alias into the array.
    assign cap_ok    = {1'b0, cap_addr} < DEPTH_L;
    assign ld_ok     = ld_en && !rst && ({1'b0, ld_addr} < DEPTH_L);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        cap_addr = addr_q;
        capture  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d   = req_addr;
                    cap_addr = req_addr;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        capture = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory is read before this edge's load lands, so a same-edge load returns old data.
    always_comb begin
        instr_d = instr_q;
        err_d   = err_q;
        if (capture) begin
            if (cap_ok) begin
                instr_d = mem[cap_addr[IDX_W-1:0]];
                err_d   = 1'b0;
            end else begin
                instr_d = '0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_addr[IDX_W-1:0]] <= ld_data;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_instr = instr_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mod_instruction_mem.sv
// Bench for mod_instruction_mem: three instances (WAIT_CYCLES 1, 0, 3) checked
// against a reference memory model through an expected-response queue.
module tb_mod_instruction_mem;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [ND-1:0] rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ld_en, busy;
    logic [AW-1:0] req_addr [ND];
    logic [AW-1:0] ld_addr  [ND];
    logic [DW-1:0] ld_data  [ND];
    logic [DW-1:0] rsp_instr[ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mod_instruction_mem #(
            .ADDR_W     (AW),
            .DATA_W     (DW),
            .DEPTH      (256),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr (req_addr[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_instr(rsp_instr[g]),
            .rsp_err  (rsp_err[g]),
            .ld_en    (ld_en[g]),
            .ld_addr  (ld_addr[g]),
            .ld_data  (ld_data[g]),
            .busy     (busy[g])
        );
    end

    typedef struct packed {
        logic [DW-1:0] instr;
        logic          err;
    } exp_t;

    exp_t        exp_q[$];
    logic [DW-1:0] model [ND][256];
    int          checks   = 0;
    int          failures = 0;

    function automatic int wc(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
        ld_en[d]   = 1'b1;
        ld_addr[d] = a;
        ld_data[d] = v;
        if (a < 256) model[d][a[7:0]] = v;
        tick;
        ld_en[d] = 1'b0;
    endtask

    task automatic start_fetch(input int d, input logic [AW-1:0] a, output exp_t e);
        int lat;
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        #1;
        checks++;
        if (req_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_idle dut%0d addr=%0d got=%b exp=1", d, a, req_ready[d]);
        end
        if (a < 256) begin
            e.instr = model[d][a[7:0]];
            e.err   = 1'b0;
        end else begin
            e.instr = '0;
            e.err   = 1'b1;
        end
        exp_q.push_back(e);
        tick;
        req_valid[d] = 1'b0;
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 32) begin
            tick;
            lat++;
        end
        e = exp_q.pop_front();
        checks++;
        if (rsp_valid[d] !== 1'b1) begin
            failures++;
            $display("FAIL rsp_timeout dut%0d addr=%0d got=no_rsp exp=latency %0d", d, a, 1 + wc(d));
        end else if (lat != 1 + wc(d)) begin
            failures++;
            $display("FAIL rsp_latency dut%0d addr=%0d got=%0d exp=%0d", d, a, lat, 1 + wc(d));
        end
        checks++;
        if (rsp_instr[d] !== e.instr) begin
            failures++;
            $display("FAIL rsp_instr dut%0d addr=%0d got=%h exp=%h", d, a, rsp_instr[d], e.instr);
        end
        checks++;
        if (rsp_err[d] !== e.err) begin
            failures++;
            $display("FAIL rsp_err dut%0d addr=%0d got=%b exp=%b", d, a, rsp_err[d], e.err);
        end
        checks++;
        if (busy[d] !== 1'b1 || req_ready[d] !== 1'b0) begin
            failures++;
            $display("FAIL resp_flags dut%0d got busy=%b req_ready=%b exp busy=1 req_ready=0",
                     d, busy[d], req_ready[d]);
        end
    endtask

    task automatic finish_fetch(input int d, input exp_t e, input int hold);
        for (int k = 0; k < hold; k++) begin
            tick;
            checks++;
            if (rsp_valid[d] !== 1'b1 || rsp_instr[d] !== e.instr || rsp_err[d] !== e.err ||
                req_ready[d] !== 1'b0 || busy[d] !== 1'b1) begin
                failures++;
                $display("FAIL resp_hold dut%0d cyc=%0d got v=%b i=%h e=%b rdy=%b busy=%b exp v=1 i=%h e=%b rdy=0 busy=1",
                         d, k, rsp_valid[d], rsp_instr[d], rsp_err[d], req_ready[d], busy[d],
                         e.instr, e.err);
            end
        end
        rsp_ready[d] = 1'b1;
        #1;
        checks++;
        if (req_ready[d] !== 1'b0) begin
            failures++;
            $display("FAIL handshake_ready dut%0d got=%b exp=0", d, req_ready[d]);
        end
        tick;
        rsp_ready[d] = 1'b0;
        checks++;
        if (rsp_valid[d] !== 1'b0 || busy[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL post_handshake dut%0d got v=%b busy=%b rdy=%b exp v=0 busy=0 rdy=1",
                     d, rsp_valid[d], busy[d], req_ready[d]);
        end
    endtask

    task automatic fetch(input int d, input logic [AW-1:0] a, input int hold);
        exp_t e;
        start_fetch(d, a, e);
        finish_fetch(d, e, hold);
    endtask

    task automatic test_reset;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready dut%0d got=%b exp=0", d, req_ready[d]);
            end
        end
        tick;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (rsp_valid[d] !== 1'b0 || busy[d] !== 1'b0 || rsp_instr[d] !== '0 || rsp_err[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state dut%0d got v=%b busy=%b i=%h e=%b exp all zero",
                         d, rsp_valid[d], busy[d], rsp_instr[d], rsp_err[d]);
            end
        end
        rst = '0;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin
                failures++;
                $display("FAIL ready_after_reset dut%0d got=%b exp=1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_basic;
        load(0, 0, 32'h00221820);
        fetch(0, 0, 0);
        for (int i = 1; i < 4; i++) load(0, AW'(i), $urandom);
        for (int i = 1; i < 4; i++) fetch(0, AW'(i), 1);
    endtask

    task automatic test_zero_wait;
        load(1, 1, 32'h0485FFFF);
        fetch(1, 1, 5);
    endtask

    task automatic test_out_of_range;
        fetch(0, 300, 0);
        load(0, 300, 32'h12345678);
        fetch(0, 300, 0);
        load(0, 255, 32'h5A5A00FF);
        fetch(0, 255, 0);
        fetch(0, 256, 0);
        load(0, 2, 32'h08000020);
        load(0, 258, 32'hDEADBEEF);
        fetch(0, 258, 0);
        fetch(0, 2, 0);
        fetch(0, 30'h2000_0002, 0);
    endtask

    task automatic test_load_during_resp;
        exp_t e;
        load(0, 2, 32'h08000020);
        start_fetch(0, 2, e);
        ld_en[0]   = 1'b1;
        ld_addr[0] = 2;
        ld_data[0] = 32'hFFFFFFFF;
        model[0][2] = 32'hFFFFFFFF;
        tick;
        ld_en[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_instr[0] !== 32'h08000020) begin
            failures++;
            $display("FAIL resp_load_hold got v=%b i=%h exp v=1 i=08000020", rsp_valid[0], rsp_instr[0]);
        end
        finish_fetch(0, e, 1);
        fetch(0, 2, 0);
    endtask

    task automatic test_reset_mid_wait;
        load(2, 4, 32'h0BADF00D);
        req_valid[2] = 1'b1;
        req_addr[2]  = 4;
        tick;
        req_valid[2] = 1'b0;
        tick;
        checks++;
        if (busy[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
            failures++;
            $display("FAIL mid_wait dut2 got busy=%b v=%b exp busy=1 v=0", busy[2], rsp_valid[2]);
        end
        rst[2]     = 1'b1;
        ld_en[2]   = 1'b1;
        ld_addr[2] = 4;
        ld_data[2] = 32'hDEADBEEF;
        tick;
        rst[2]   = 1'b0;
        ld_en[2] = 1'b0;
        #1;
        checks++;
        if (busy[2] !== 1'b0 || rsp_valid[2] !== 1'b0 || rsp_instr[2] !== '0 || rsp_err[2] !== 1'b0 ||
            req_ready[2] !== 1'b1) begin
            failures++;
            $display("FAIL wait_reset dut2 got busy=%b v=%b i=%h e=%b rdy=%b exp 0 0 0 0 1",
                     busy[2], rsp_valid[2], rsp_instr[2], rsp_err[2], req_ready[2]);
        end
        for (int k = 0; k < 8; k++) begin
            tick;
            checks++;
            if (rsp_valid[2] !== 1'b0) begin
                failures++;
                $display("FAIL abandoned_rsp dut2 cyc=%0d got=%b exp=0", k, rsp_valid[2]);
            end
        end
        fetch(2, 4, 0);
    endtask

    task automatic test_ld_priority;
        exp_t e;
        ld_en[0]     = 1'b1;
        ld_addr[0]   = 7;
        ld_data[0]   = 32'hC0FFEE07;
        model[0][7]  = 32'hC0FFEE07;
        req_valid[0] = 1'b1;
        req_addr[0]  = 7;
        #1;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL ld_priority_ready got=%b exp=0", req_ready[0]);
        end
        tick;
        ld_en[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL ld_priority_busy got=%b exp=0", busy[0]);
        end
        start_fetch(0, 7, e);
        finish_fetch(0, e, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) load(0, AW'(16 + i), $urandom);
        for (int i = 0; i < 6; i++) fetch(0, AW'(16 + i), i % 3);
        load(2, 9, $urandom);
        load(2, 10, $urandom);
        fetch(2, 9, 0);
        fetch(2, 10, 2);
        fetch(2, 400, 0);
    endtask

    initial begin
        rst       = '1;
        req_valid = '0;
        rsp_ready = '0;
        ld_en     = '0;
        for (int d = 0; d < ND; d++) begin
            req_addr[d] = '0;
            ld_addr[d]  = '0;
            ld_data[d]  = '0;
        end
        tick;
        test_reset;
        test_basic;
        test_zero_wait;
        test_out_of_range;
        test_load_during_resp;
        test_reset_mid_wait;
        test_ld_priority;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
